// File: rtl/nic_master_message_buffer.sv
// rtl/nic_master_message_buffer.sv - outbound message buffer feeding the NIC Wishbone master
//
// Stores complete messages (write-data words first, then the header that
// commits them) and presents the head message first-word-fall-through.
// Optional feature macro: NIC_MASTER_BUF_RETRY_LIMIT_EN (bounded retries, drop_o).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dat_wr_i, dat_i          push one write-data word
//   hdr_wr_i + header fields push a header, committing the message
//   hdr_full_o, dat_free_o   free-space status
//   wr_err_o                 one-cycle pulse on a rejected push
//   r_bus_arbitration_o      a committed message is at the head
//   address_o .. data_o      head-message header and current data word
//   next_data_i              advance to the next data word
//   message_transmitted_i    pop the head message
//   retry_i                  rewind the head message to its first word
//   drop_o                   head message dropped after too many retries

`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_TGA_WIDTH
`define BUS_TGA_WIDTH 8
`endif
`ifndef BUS_TGC_WIDTH
`define BUS_TGC_WIDTH 8
`endif
`ifndef GRANULARITY
`define GRANULARITY 8
`endif
`ifndef MAX_BURST_LENGHT
`define MAX_BURST_LENGHT 8
`endif

module nic_master_message_buffer #(
  parameter int MAX_BURST_LENGTH    = `MAX_BURST_LENGHT,
  parameter int N_BITS_BURST_LENGTH = $clog2(MAX_BURST_LENGTH + 1),
  parameter int HDR_DEPTH           = 2,
  parameter int DATA_DEPTH          = 16,
  parameter int RETRY_LIMIT         = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      dat_wr_i,
  input  logic [`BUS_DATA_WIDTH-1:0]                dat_i,
  input  logic                                      hdr_wr_i,
  input  logic [`BUS_ADDRESS_WIDTH-1:0]             address_i,
  input  logic [`BUS_TGA_WIDTH-1:0]                 tga_i,
  input  logic [`BUS_TGC_WIDTH-1:0]                 tgc_i,
  input  logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0]   sel_i,
  input  logic                                      transaction_type_i,
  input  logic [N_BITS_BURST_LENGTH-1:0]            burst_length_i,
  output logic                                      hdr_full_o,
  output logic [$clog2(DATA_DEPTH+1)-1:0]           dat_free_o,
  output logic                                      wr_err_o,
  output logic                                      r_bus_arbitration_o,
  output logic [`BUS_ADDRESS_WIDTH-1:0]             address_o,
  output logic [`BUS_TGA_WIDTH-1:0]                 tga_o,
  output logic [`BUS_TGC_WIDTH-1:0]                 tgc_o,
  output logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0]   sel_o,
  output logic                                      transaction_type_o,
  output logic [N_BITS_BURST_LENGTH-1:0]            burst_length_o,
  output logic [`BUS_DATA_WIDTH-1:0]                data_o,
  input  logic                                      next_data_i,
  input  logic                                      message_transmitted_i,
  input  logic                                      retry_i,
  output logic                                      drop_o
);

  localparam int HA = $clog2(HDR_DEPTH);
  localparam int DA = $clog2(DATA_DEPTH);
  localparam int HP = HA + 1;
  localparam int DP = DA + 1;
  localparam int FW = $clog2(DATA_DEPTH + 1);
  localparam int NB = N_BITS_BURST_LENGTH;
  localparam int SW = `BUS_DATA_WIDTH / `GRANULARITY;

  localparam logic [HP-1:0] HP_ONE = HP'(1);
  localparam logic [DP-1:0] DP_ONE = DP'(1);
  localparam logic [NB-1:0] MAX_BL = NB'(MAX_BURST_LENGTH);

  if (DATA_DEPTH < MAX_BURST_LENGTH) begin : g_bad_depth
    $error("DATA_DEPTH must be at least MAX_BURST_LENGTH");
  end
  if (RETRY_LIMIT < 1) begin : g_bad_retry_limit
    $error("RETRY_LIMIT must be at least 1");
  end

  logic [`BUS_ADDRESS_WIDTH-1:0] hdr_addr  [HDR_DEPTH];
  logic [`BUS_TGA_WIDTH-1:0]     hdr_tga   [HDR_DEPTH];
  logic [`BUS_TGC_WIDTH-1:0]     hdr_tgc   [HDR_DEPTH];
  logic [SW-1:0]                 hdr_sel   [HDR_DEPTH];
  logic                          hdr_type  [HDR_DEPTH];
  logic [NB-1:0]                 hdr_burst [HDR_DEPTH];
  logic [`BUS_DATA_WIDTH-1:0]    dat_mem   [DATA_DEPTH];

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [HP-1:0] hdr_wptr, hdr_rptr;
  logic [DP-1:0] dat_wptr, base_ptr, cur_ptr;
  logic [FW-1:0] dat_free_q;
  logic          wr_err_q;

  logic          avail, head_write;
  logic [NB-1:0] head_burst;
  logic [DP-1:0] burst_ext, cur_off, last_off;
  logic          dat_push, dat_err, hdr_bad, hdr_push, hdr_err;
  logic          pop, rewind, advance, drop_req;
  logic [FW-1:0] freed;

  assign avail      = hdr_wptr != hdr_rptr;
  assign hdr_full_o = (hdr_wptr[HA] != hdr_rptr[HA]) &&
                      (hdr_wptr[HA-1:0] == hdr_rptr[HA-1:0]);
  assign head_write = hdr_type[hdr_rptr[HA-1:0]];
  assign head_burst = hdr_burst[hdr_rptr[HA-1:0]];
  assign burst_ext  = DP'(head_burst);
  assign cur_off    = cur_ptr - base_ptr;
  assign last_off   = burst_ext - DP_ONE;

  assign dat_push = dat_wr_i && (dat_free_q != '0);
  assign dat_err  = dat_wr_i && (dat_free_q == '0);
  assign hdr_bad  = (burst_length_i == '0) || (burst_length_i > MAX_BL);
  assign hdr_push = hdr_wr_i && !hdr_full_o && !hdr_bad;
  assign hdr_err  = hdr_wr_i && !hdr_push;

  // Priority on the read side: completion (or a limit drop) over retry over advance.
  assign pop     = avail && (message_transmitted_i || drop_req);
  assign rewind  = avail && retry_i && !message_transmitted_i && !drop_req;
  assign advance = avail && next_data_i && head_write && !pop && !rewind &&
                   (cur_off != last_off);
  assign freed   = (pop && head_write) ? FW'(head_burst) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_wptr   <= '0;
      hdr_rptr   <= '0;
      dat_wptr   <= '0;
      base_ptr   <= '0;
      cur_ptr    <= '0;
      dat_free_q <= FW'(DATA_DEPTH);
      wr_err_q   <= 1'b0;
    end else begin
      if (hdr_push) hdr_wptr <= hdr_wptr + HP_ONE;
      if (pop)      hdr_rptr <= hdr_rptr + HP_ONE;
      if (dat_push) dat_wptr <= dat_wptr + DP_ONE;
      if (pop && head_write) begin
        base_ptr <= base_ptr + burst_ext;
        cur_ptr  <= base_ptr + burst_ext;
      end else if (rewind) begin
        cur_ptr <= base_ptr;
      end else if (advance) begin
        cur_ptr <= cur_ptr + DP_ONE;
      end
      dat_free_q <= dat_free_q - FW'(dat_push) + freed;
      wr_err_q   <= dat_err || hdr_err;
    end
  end

  always_ff @(posedge clk) begin
    if (dat_push) dat_mem[dat_wptr[DA-1:0]] <= dat_i;
    if (hdr_push) begin
      hdr_addr[hdr_wptr[HA-1:0]]  <= address_i;
      hdr_tga[hdr_wptr[HA-1:0]]   <= tga_i;
      hdr_tgc[hdr_wptr[HA-1:0]]   <= tgc_i;
      hdr_sel[hdr_wptr[HA-1:0]]   <= sel_i;
      hdr_type[hdr_wptr[HA-1:0]]  <= transaction_type_i;
      hdr_burst[hdr_wptr[HA-1:0]] <= burst_length_i;
    end
  end

`ifdef NIC_MASTER_BUF_RETRY_LIMIT_EN
  localparam int RW = $clog2(RETRY_LIMIT + 1);
  logic [RW-1:0] retry_cnt;
  logic          drop_q;

  // The retry that would reach the limit drops the message instead of rewinding.
  assign drop_req = avail && retry_i && !message_transmitted_i &&
                    (retry_cnt == RW'(RETRY_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= drop_req;
      if (pop)         retry_cnt <= '0;
      else if (rewind) retry_cnt <= retry_cnt + RW'(1);
    end
  end

  assign drop_o = drop_q;
`else
  assign drop_req = 1'b0;
  assign drop_o   = 1'b0;
`endif

  assign r_bus_arbitration_o = avail;
  assign dat_free_o          = dat_free_q;
  assign wr_err_o            = wr_err_q;
  assign address_o           = hdr_addr[hdr_rptr[HA-1:0]];
  assign tga_o               = hdr_tga[hdr_rptr[HA-1:0]];
  assign tgc_o               = hdr_tgc[hdr_rptr[HA-1:0]];
  assign sel_o               = hdr_sel[hdr_rptr[HA-1:0]];
  assign transaction_type_o  = head_write;
  assign burst_length_o      = head_burst;
  assign data_o              = dat_mem[cur_ptr[DA-1:0]];

endmodule

// File: tb/tb_nic_master_message_buffer.sv
// tb/tb_nic_master_message_buffer.sv - directed self-checking bench for nic_master_message_buffer

`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_TGA_WIDTH
`define BUS_TGA_WIDTH 8
`endif
`ifndef BUS_TGC_WIDTH
`define BUS_TGC_WIDTH 8
`endif
`ifndef GRANULARITY
`define GRANULARITY 8
`endif
`ifndef MAX_BURST_LENGHT
`define MAX_BURST_LENGHT 8
`endif

module tb_nic_master_message_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        dat_wr_i;
  logic [31:0] dat_i;
  logic        hdr_wr_i;
  logic [31:0] address_i;
  logic [7:0]  tga_i;
  logic [7:0]  tgc_i;
  logic [3:0]  sel_i;
  logic        transaction_type_i;
  logic [3:0]  burst_length_i;
  logic        hdr_full_o;
  logic [4:0]  dat_free_o;
  logic        wr_err_o;
  logic        r_bus_arbitration_o;
  logic [31:0] address_o;
  logic [7:0]  tga_o;
  logic [7:0]  tgc_o;
  logic [3:0]  sel_o;
  logic        transaction_type_o;
  logic [3:0]  burst_length_o;
  logic [31:0] data_o;
  logic        next_data_i;
  logic        message_transmitted_i;
  logic        retry_i;
  logic        drop_o;

  int errors = 0;
  int checks = 0;

  nic_master_message_buffer dut (
    .clk                   (clk),
    .rst                   (rst),
    .dat_wr_i              (dat_wr_i),
    .dat_i                 (dat_i),
    .hdr_wr_i              (hdr_wr_i),
    .address_i             (address_i),
    .tga_i                 (tga_i),
    .tgc_i                 (tgc_i),
    .sel_i                 (sel_i),
    .transaction_type_i    (transaction_type_i),
    .burst_length_i        (burst_length_i),
    .hdr_full_o            (hdr_full_o),
    .dat_free_o            (dat_free_o),
    .wr_err_o              (wr_err_o),
    .r_bus_arbitration_o   (r_bus_arbitration_o),
    .address_o             (address_o),
    .tga_o                 (tga_o),
    .tgc_o                 (tgc_o),
    .sel_o                 (sel_o),
    .transaction_type_o    (transaction_type_o),
    .burst_length_o        (burst_length_o),
    .data_o                (data_o),
    .next_data_i           (next_data_i),
    .message_transmitted_i (message_transmitted_i),
    .retry_i               (retry_i),
    .drop_o                (drop_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    dat_wr_i = 1'b1;
    dat_i    = d;
    tick();
    dat_wr_i = 1'b0;
  endtask

  task automatic push_hdr(input logic [31:0] a, input logic typ, input logic [3:0] bl);
    hdr_wr_i           = 1'b1;
    address_i          = a;
    transaction_type_i = typ;
    burst_length_i     = bl;
    tick();
    hdr_wr_i = 1'b0;
  endtask

  task automatic pulse_next();
    next_data_i = 1'b1;
    tick();
    next_data_i = 1'b0;
  endtask

  task automatic pulse_done();
    message_transmitted_i = 1'b1;
    tick();
    message_transmitted_i = 1'b0;
  endtask

  task automatic pulse_retry();
    retry_i = 1'b1;
    tick();
    retry_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dat_wr_i = 1'b0; dat_i = '0; hdr_wr_i = 1'b0; address_i = '0;
    tga_i = 8'h5A; tgc_i = 8'hC3; sel_i = 4'hF;
    transaction_type_i = 1'b0; burst_length_i = '0;
    next_data_i = 1'b0; message_transmitted_i = 1'b0; retry_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("reset_arb", r_bus_arbitration_o, 0);
    chk("reset_free", dat_free_o, 16);
    chk("reset_full", hdr_full_o, 0);
    chk("reset_err", wr_err_o, 0);
    chk("reset_drop", drop_o, 0);

    // Single burst-5 write message, FWFT and saturation
    for (int i = 0; i < 5; i++) push_word(32'h10 + i);
    chk("m1_free_before_hdr", dat_free_o, 11);
    chk("m1_arb_before_hdr", r_bus_arbitration_o, 0);
    push_hdr(32'h1000, 1'b1, 4'd5);
    chk("m1_arb", r_bus_arbitration_o, 1);
    chk("m1_data0", data_o, 32'h10);
    chk("m1_addr", address_o, 32'h1000);
    chk("m1_burst", burst_length_o, 5);
    chk("m1_type", transaction_type_o, 1);
    chk("m1_tga", tga_o, 8'h5A);
    chk("m1_tgc", tgc_o, 8'hC3);
    chk("m1_sel", sel_o, 4'hF);
    for (int i = 0; i < 5; i++) begin
      pulse_next();
      chk($sformatf("m1_step%0d", i), data_o, (i < 4) ? 32'h11 + i : 32'h14);
    end
    pulse_done();
    chk("m1_arb_after_pop", r_bus_arbitration_o, 0);
    chk("m1_free_after_pop", dat_free_o, 16);

    // Two messages fill the header FIFO; third header rejected
    for (int i = 0; i < 3; i++) push_word(32'h20 + i);
    push_hdr(32'hA, 1'b1, 4'd3);
    push_word(32'h30);
    push_word(32'h31);
    push_hdr(32'hB, 1'b1, 4'd2);
    chk("q2_full", hdr_full_o, 1);
    chk("q2_free", dat_free_o, 11);
    push_hdr(32'hC, 1'b1, 4'd1);
    chk("q2_err_pulse", wr_err_o, 1);
    chk("q2_head_addr", address_o, 32'hA);
    tick();
    chk("q2_err_clear", wr_err_o, 0);
    chk("q2_head_data", data_o, 32'h20);
    pulse_done();
    chk("q2_msg2_addr", address_o, 32'hB);
    chk("q2_msg2_data", data_o, 32'h30);
    chk("q2_not_full", hdr_full_o, 0);
    chk("q2_free_after_pop", dat_free_o, 14);

    // Retry rewinds; retry together with completion pops
    pulse_next();
    pulse_next();
    chk("rt_data_sat", data_o, 32'h31);
    pulse_retry();
    chk("rt_rewind", data_o, 32'h30);
    chk("rt_still_arb", r_bus_arbitration_o, 1);
    retry_i = 1'b1;
    message_transmitted_i = 1'b1;
    tick();
    retry_i = 1'b0;
    message_transmitted_i = 1'b0;
    chk("rt_pop_wins_arb", r_bus_arbitration_o, 0);
    chk("rt_pop_wins_free", dat_free_o, 16);

    // Fill 14 slots, overflow the data FIFO, drain
    for (int i = 0; i < 7; i++) push_word(32'h40 + i);
    push_hdr(32'hC0, 1'b1, 4'd7);
    for (int i = 0; i < 7; i++) push_word(32'h50 + i);
    push_hdr(32'hD0, 1'b1, 4'd7);
    chk("fill_free14", dat_free_o, 2);
    push_word(32'h60);
    push_word(32'h61);
    chk("fill_free0", dat_free_o, 0);
    push_word(32'h99);
    chk("fill_overflow_err", wr_err_o, 1);
    chk("fill_overflow_free", dat_free_o, 0);
    chk("fill_c_data", data_o, 32'h40);
    pulse_done();
    chk("fill_d_data", data_o, 32'h50);
    chk("fill_free_after_c", dat_free_o, 7);
    pulse_done();
    chk("fill_free_after_d", dat_free_o, 14);
    chk("fill_arb_empty", r_bus_arbitration_o, 0);

    // Burst-6 message starting with the two held words (0x60, 0x61)
    for (int i = 0; i < 4; i++) push_word(32'h62 + i);
    push_hdr(32'hE0, 1'b1, 4'd6);
    chk("m6_free", dat_free_o, 10);
    chk("m6_data0", data_o, 32'h60);
    for (int i = 1; i < 6; i++) begin
      pulse_next();
      chk($sformatf("m6_word%0d", i), data_o, 32'h60 + i);
    end
    pulse_done();
    chk("m6_free_after", dat_free_o, 16);

    // Burst-4 message straddling the pointer wrap
    for (int i = 0; i < 4; i++) push_word(32'h70 + i);
    push_hdr(32'hF0, 1'b1, 4'd4);
    chk("wrap_free", dat_free_o, 12);
    chk("wrap_data0", data_o, 32'h70);
    for (int i = 1; i < 4; i++) begin
      pulse_next();
      chk($sformatf("wrap_word%0d", i), data_o, 32'h70 + i);
    end
    // Simultaneous pop and push: +4 freed -1 pushed
    message_transmitted_i = 1'b1;
    dat_wr_i = 1'b1;
    dat_i = 32'h80;
    tick();
    message_transmitted_i = 1'b0;
    dat_wr_i = 1'b0;
    chk("pushpop_free", dat_free_o, 15);
    chk("pushpop_arb", r_bus_arbitration_o, 0);

    // Read message: no data movement
    push_hdr(32'h2000, 1'b0, 4'd4);
    chk("rd_arb", r_bus_arbitration_o, 1);
    chk("rd_type", transaction_type_o, 0);
    pulse_next();
    chk("rd_next_ignored", data_o, 32'h80);
    pulse_done();
    chk("rd_free_unchanged", dat_free_o, 15);
    chk("rd_arb_after", r_bus_arbitration_o, 0);

    // Invalid burst lengths
    push_hdr(32'h3000, 1'b1, 4'd0);
    chk("bl0_err", wr_err_o, 1);
    chk("bl0_not_stored", r_bus_arbitration_o, 0);
    push_hdr(32'h3001, 1'b1, 4'd9);
    chk("bl9_err", wr_err_o, 1);
    chk("bl9_not_stored", r_bus_arbitration_o, 0);

    // Repeated retries
    push_word(32'h81);
    push_hdr(32'h4000, 1'b1, 4'd2);
    chk("rl_data0", data_o, 32'h80);
`ifdef NIC_MASTER_BUF_RETRY_LIMIT_EN
    for (int i = 0; i < 3; i++) begin
      pulse_retry();
      chk($sformatf("rl_no_drop%0d", i), drop_o, 0);
    end
    pulse_retry();
    chk("rl_drop", drop_o, 1);
    chk("rl_dropped_arb", r_bus_arbitration_o, 0);
    chk("rl_dropped_free", dat_free_o, 16);
`else
    for (int i = 0; i < 10; i++) begin
      pulse_retry();
      chk($sformatf("rl_no_drop%0d", i), drop_o, 0);
    end
    chk("rl_still_arb", r_bus_arbitration_o, 1);
    pulse_done();
    chk("rl_final_free", dat_free_o, 16);
`endif

    // Mid-operation reset discards stored messages
    push_word(32'h90);
    push_hdr(32'h5000, 1'b1, 4'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_arb", r_bus_arbitration_o, 0);
    chk("rst_mid_free", dat_free_o, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
